// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//  Control unit for a multi-cycle MIPS datapath. It holds the main decode state
//  machine, decodes the ALU operation and drives the PC enable. Beyond
//  lw/sw/R-type/beq it can decode bne, addi and j; each of these can be switched
//  off by a parameter, and a disabled opcode is then reported as illegal.
//  mem_ready lets instruction and data memory stretch FETCH, MEMRD and MEMWR.
// Ports
//  clk, reset          rising-edge clock, synchronous active-high reset
//  op, funct           instruction fields taken from the instruction register
//  zero                ALU zero flag (branch resolve)
//  mem_ready           memory access completes this cycle
//  pcen..regwrite      register and memory enables
//  alusrca/iord/memtoreg/regdst, alusrcb, pcsrc   datapath mux selects
//  alucontrol          ALU operation, 3-bit code zero-extended to ALUCTRL_W
//  illegal             one-cycle pulse on an unsupported op or funct
//  instr_done          pulse on the last cycle of each instruction
//  state_o             current state, for debug
module multicycle_ctrl_fsm #(
  parameter int ALUCTRL_W = 3,
  parameter int EN_BNE    = 1,
  parameter int EN_ADDI   = 1,
  parameter int EN_JUMP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic                 iord,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic                 instr_done,
  output logic [3:0]           state_o
);
  localparam logic [3:0] FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,
                         MEMRD  = 4'd3,  MEMWB  = 4'd4,  MEMWR  = 4'd5,
                         RTEX   = 4'd6,  RTWB   = 4'd7,  BEQEX  = 4'd8,
                         ADDIEX = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11,
                         BNEEX  = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_ADDI = 6'b001000, OP_J = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR = 3'b001, ALU_SLT = 3'b111;

  logic [3:0] state, next_state;
  logic [2:0] alu3;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  assign state_o    = state;
  assign alucontrol = ALUCTRL_W'(alu3);

  always_comb begin
    next_state = FETCH;
    pcen = 1'b0; memread = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
    regwrite = 1'b0; alusrca = 1'b0; iord = 1'b0; memtoreg = 1'b0;
    regdst = 1'b0; alusrcb = 2'b00; pcsrc = 2'b00; alu3 = ALU_ADD;
    illegal = 1'b0; instr_done = 1'b0;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // IR load and PC+4 only commit once the fetch actually returns
        irwrite = mem_ready;
        pcen    = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes the branch target during decode
        alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW)         next_state = MEMADR;
        else if (op == OP_R)                    next_state = RTEX;
        else if (op == OP_BEQ)                  next_state = BEQEX;
        else if (op == OP_BNE  && EN_BNE  != 0) next_state = BNEEX;
        else if (op == OP_ADDI && EN_ADDI != 0) next_state = ADDIEX;
        else if (op == OP_J    && EN_JUMP != 0) next_state = JEX;
        else begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // only lw and sw reach this state
        next_state = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        next_state = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        next_state = mem_ready ? FETCH : MEMWR;
      end
      RTEX: begin
        alusrca    = 1'b1;
        next_state = RTWB;
        case (funct)
          6'b100000: alu3 = ALU_ADD;
          6'b100010: alu3 = ALU_SUB;
          6'b100100: alu3 = ALU_AND;
          6'b100101: alu3 = ALU_OR;
          6'b101010: alu3 = ALU_SLT;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      RTWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca    = 1'b1;
        alu3       = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = (state == BEQEX) ? zero : ~zero;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: next_state = FETCH;  // codes 13-15 recover with everything off
    endcase
    // an instruction aborted by reset must not write anything in that cycle
    if (reset) begin
      pcen = 1'b0; memread = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
      regwrite = 1'b0; illegal = 1'b0; instr_done = 1'b0;
    end
  end
endmodule
